color_cmd_feeder: RTL and testbench

- Upstream stage of the Color Mealy FSM.
- Accepts 2-bit colour commands over a valid/ready interface and buffers them in a small FIFO.
- Issues each command to the FSM's `in` port for exactly one cycle, followed by a programmable run of idle cycles.
- Drives the idle code 2'h3 whenever no command is being issued; the FSM ignores 2'h3 in every state.

---
 rtl/color_feed_pkg.sv | 20 ++
 rtl/color_cmd_feeder_if.sv | 9 +
 rtl/color_cmd_fifo.sv | 55 +++++
 rtl/color_cmd_feeder.sv | 124 ++++++++++++
 tb/tb_color_cmd_feeder.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/color_feed_pkg.sv
// Shared types and command codes for the colour command feeder.
// The feeder sits upstream of the Color Mealy FSM.
package color_feed_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    GAP_WAIT = 2'd2
  } feeder_state_t;

  localparam logic [1:0] CMD_HOLD   = 2'h0;
  localparam logic [1:0] CMD_TOGGLE = 2'h1;
  localparam logic [1:0] CMD_IDLE   = 2'h3;
  localparam int         GAP_W      = 4;

  function automatic logic is_legal_cmd(input logic [1:0] c);
    return (c == CMD_HOLD) || (c == CMD_TOGGLE);
  endfunction

endpackage

// File: rtl/color_cmd_feeder_if.sv
// Valid/ready command stream into the colour command feeder.
interface color_cmd_feeder_if;
  logic       cmd_valid;
  logic [1:0] cmd_data;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_data, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_data, output cmd_ready);
endinterface

// File: rtl/color_cmd_fifo.sv
// Small power-of-two FIFO holding queued colour commands; head is read combinationally.
module color_cmd_fifo
  import color_feed_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointers wrap naturally at DEPTH; count tells full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/color_cmd_feeder.sv
// Buffers colour commands and issues each one to the Color FSM for a single
// cycle followed by GAP idle cycles; 2'h3 is driven whenever nothing is issued.
module color_cmd_feeder
  import color_feed_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int GAP   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  color_cmd_feeder_if.slave      cmd,
  input  logic                   flush,
  output logic [1:0]             fsm_in,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             drop_cnt
);

  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

  feeder_state_t    state;
  logic [GAP_W-1:0] gap_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic [1:0]       fifo_head;
  logic             xfer;
  logic             push;
  logic             pop;

  assign cmd.cmd_ready = !fifo_full && !flush;
  assign xfer          = cmd.cmd_valid && cmd.cmd_ready;
  assign push          = xfer && is_legal_cmd(cmd.cmd_data);

  color_cmd_fifo #(.DEPTH(DEPTH), .W(2)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data (cmd.cmd_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  // Pop whenever the sequencer is about to start a new issue slot.
  always_comb begin
    pop = 1'b0;
    if (!flush && !fifo_empty) begin
      case (state)
        IDLE:     pop = 1'b1;
        ISSUE:    pop = (GAP == 0);
        GAP_WAIT: pop = (gap_cnt == '0);
        default:  pop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      fsm_in  <= CMD_IDLE;
      gap_cnt <= '0;
    end else if (flush) begin
      state   <= IDLE;
      fsm_in  <= CMD_IDLE;
      gap_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            fsm_in <= fifo_head;
            state  <= ISSUE;
          end else begin
            fsm_in <= CMD_IDLE;
          end
        end
        ISSUE: begin
          if (GAP > 0) begin
            fsm_in  <= CMD_IDLE;
            gap_cnt <= GAP_LOAD;
            state   <= GAP_WAIT;
          end else if (pop) begin
            fsm_in <= fifo_head;
          end else begin
            fsm_in <= CMD_IDLE;
            state  <= IDLE;
          end
        end
        GAP_WAIT: begin
          if (gap_cnt == '0) begin
            if (pop) begin
              fsm_in <= fifo_head;
              state  <= ISSUE;
            end else begin
              fsm_in <= CMD_IDLE;
              state  <= IDLE;
            end
          end else begin
            fsm_in  <= CMD_IDLE;
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          fsm_in <= CMD_IDLE;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Illegal commands are swallowed; flush leaves the tally alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (xfer && !is_legal_cmd(cmd.cmd_data) && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign busy = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_color_cmd_feeder.sv
// Bench for color_cmd_feeder: two instances (GAP=1 and GAP=0) against a
// queue-based timing model, plus directed literal expectations.
module tb_color_cmd_feeder;

  localparam int DEPTH   = 4;
  localparam int GAPS[2] = '{1, 0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vld  [2];
  logic [1:0] dat  [2];
  logic       flsh [2];
  logic       rdy  [2];
  logic [1:0] fsm  [2];
  logic       bsy  [2];
  logic [2:0] cnt  [2];
  logic [7:0] drp  [2];

  logic [1:0] fsm0, fsm1;
  logic       bsy0, bsy1;
  logic [2:0] cnt0, cnt1;
  logic [7:0] drp0, drp1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  color_cmd_feeder_if if0 ();
  color_cmd_feeder_if if1 ();

  assign if0.cmd_valid = vld[0];
  assign if0.cmd_data  = dat[0];
  assign if1.cmd_valid = vld[1];
  assign if1.cmd_data  = dat[1];
  assign rdy[0] = if0.cmd_ready;
  assign rdy[1] = if1.cmd_ready;
  assign fsm[0] = fsm0;
  assign fsm[1] = fsm1;
  assign bsy[0] = bsy0;
  assign bsy[1] = bsy1;
  assign cnt[0] = cnt0;
  assign cnt[1] = cnt1;
  assign drp[0] = drp0;
  assign drp[1] = drp1;

  color_cmd_feeder #(.DEPTH(DEPTH), .GAP(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cmd(if0.slave), .flush(flsh[0]),
    .fsm_in(fsm0), .busy(bsy0), .count(cnt0), .drop_cnt(drp0));

  color_cmd_feeder #(.DEPTH(DEPTH), .GAP(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cmd(if1.slave), .flush(flsh[1]),
    .fsm_in(fsm1), .busy(bsy1), .count(cnt1), .drop_cnt(drp1));

  task automatic check(input string nm, input int i, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0d want %0d at %0t", nm, i, act, exp, $time);
    end
  endtask

  // Model: a command may be issued at an edge when the queue is non-empty
  // and at least GAP+1 edges have passed since the previous issue.
  logic [1:0] mq [2][$];
  logic [1:0] m_fsm [2];
  int         m_drop [2];
  int         m_earliest [2];
  int         m_cyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mq[i].delete();
        m_fsm[i]      = 2'h3;
        m_drop[i]     = 0;
        m_earliest[i] = 0;
      end
      m_cyc = 0;
    end else begin
      m_cyc++;
      for (int i = 0; i < 2; i++) begin
        bit acc;
        acc = vld[i] && !flsh[i] && (mq[i].size() < DEPTH);
        if (flsh[i]) begin
          mq[i].delete();
          m_fsm[i]      = 2'h3;
          m_earliest[i] = 0;
        end else begin
          if (mq[i].size() > 0 && m_cyc >= m_earliest[i]) begin
            m_fsm[i]      = mq[i].pop_front();
            m_earliest[i] = m_cyc + GAPS[i] + 1;
          end else begin
            m_fsm[i] = 2'h3;
          end
          if (acc) begin
            if (dat[i] <= 2'h1) mq[i].push_back(dat[i]);
            else if (m_drop[i] < 255) m_drop[i]++;
          end
        end
      end
    end
  end

  logic [1:0] h_fsm  [2][$];
  logic       h_busy [2][$];
  int         max_cnt0 = 0;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      check("fsm_in", i, int'(fsm[i]), int'(m_fsm[i]));
      check("count", i, int'(cnt[i]), mq[i].size());
      check("busy", i, int'(bsy[i]), int'((mq[i].size() > 0) || (m_cyc < m_earliest[i])));
      check("drop_cnt", i, int'(drp[i]), m_drop[i]);
      check("cmd_ready", i, int'(rdy[i]), int'((mq[i].size() < DEPTH) && !flsh[i]));
      h_fsm[i].push_back(fsm[i]);
      h_busy[i].push_back(bsy[i]);
    end
    if (int'(cnt0) > max_cnt0) max_cnt0 = int'(cnt0);
  end

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input int i, input logic [1:0] d);
    int t;
    t = 0;
    vld[i] = 1'b1;
    dat[i] = d;
    #1;
    while (!rdy[i] && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("send_accept", i, int'(rdy[i]), 1);
    @(posedge clk);
    @(negedge clk);
    vld[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [1:0] burst [8];
  logic [1:0] got   [$];
  int         all3;

  initial begin
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0; dat[i] = 2'h0; flsh[i] = 1'b0;
    end
    burst = '{2'h1, 2'h0, 2'h0, 2'h1, 2'h1, 2'h0, 2'h1, 2'h0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_fsm_in", 0, int'(fsm0), 3);
    check("rst_busy", 0, int'(bsy0), 0);
    check("rst_count", 0, int'(cnt0), 0);
    check("rst_drop", 0, int'(drp0), 0);
    rst_n = 1'b1;
    #1;
    check("rst_ready", 0, int'(rdy[0]), 1);
    idle(2);

    // Single TOGGLE with GAP=1
    h_fsm[0].delete(); h_busy[0].delete();
    send(0, 2'h1);
    idle(4);
    check("t1_c1", 0, int'(h_fsm[0][0]), 3);
    check("t1_c2", 0, int'(h_fsm[0][1]), 1);
    check("t1_c3", 0, int'(h_fsm[0][2]), 3);
    check("t1_busy3", 0, int'(h_busy[0][2]), 1);
    check("t1_busy4", 0, int'(h_busy[0][3]), 0);
    check("t1_count", 0, int'(cnt0), 0);

    // Back-to-back burst overfills the FIFO; order must be preserved
    h_fsm[0].delete();
    max_cnt0 = 0;
    for (int k = 0; k < 8; k++) send(0, burst[k]);
    idle(25);
    check("t2_maxcnt", 0, max_cnt0, 4);
    got.delete();
    foreach (h_fsm[0][k]) if (h_fsm[0][k] != 2'h3) got.push_back(h_fsm[0][k]);
    check("t2_n_issued", 0, got.size(), 8);
    for (int k = 0; k < 8; k++) check("t2_order", k, int'(got[k]), int'(burst[k]));

    // GAP=0 back-to-back issue
    h_fsm[1].delete();
    send(1, 2'h0);
    send(1, 2'h1);
    send(1, 2'h1);
    idle(3);
    check("t3_c2", 1, int'(h_fsm[1][1]), 0);
    check("t3_c3", 1, int'(h_fsm[1][2]), 1);
    check("t3_c4", 1, int'(h_fsm[1][3]), 1);
    check("t3_c5", 1, int'(h_fsm[1][4]), 3);

    // Illegal commands
    send(0, 2'h2);
    send(0, 2'h3);
    idle(2);
    check("t4_drop2", 0, int'(drp0), 2);
    check("t4_count", 0, int'(cnt0), 0);
    vld[0] = 1'b1; dat[0] = 2'h2;
    idle(300);
    vld[0] = 1'b0;
    idle(2);
    check("t4_drop_sat", 0, int'(drp0), 255);

    // Flush while in GAP_WAIT with three entries queued
    send(0, 2'h0); send(0, 2'h1); send(0, 2'h1); send(0, 2'h0); send(0, 2'h1);
    check("t5_pre_count", 0, int'(cnt0), 3);
    flsh[0] = 1'b1;
    @(posedge clk);
    #2;
    check("t5_count", 0, int'(cnt0), 0);
    check("t5_fsm_in", 0, int'(fsm0), 3);
    check("t5_busy", 0, int'(bsy0), 0);
    check("t5_drop", 0, int'(drp0), 255);
    @(negedge clk);
    flsh[0] = 1'b0;
    idle(4);

    // Asynchronous reset while a command is on fsm_in
    send(0, 2'h1);
    send(0, 2'h0);
    check("t6_pre_issue", 0, int'(fsm0), 1);
    rst_n = 1'b0;
    #1;
    check("t6_async_fsm", 0, int'(fsm0), 3);
    check("t6_async_count", 0, int'(cnt0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    h_fsm[0].delete();
    idle(6);
    all3 = 1;
    foreach (h_fsm[0][k]) if (h_fsm[0][k] != 2'h3) all3 = 0;
    check("t6_no_stale", 0, all3, 1);
    check("t6_drop_cleared", 0, int'(drp0), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
